// File: rtl/uart_tx_arbiter_if.sv
// Requester/TX-engine side signals of the UART TX arbiter, bundled as one port.
// master is the arbiter's view; slave is the requesters plus TX engine.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]    i_REQ;
  logic [N_REQ*DW-1:0] i_DATA;
  logic [N_REQ-1:0]    o_ACK;
  logic                i_TXRDY;
  logic                o_TX_WRITE;
  logic [DW-1:0]       o_TX_DATA;
  logic [GW-1:0]       o_GRANT_ID;
  logic                o_BUSY;
  logic                o_ERR;

  modport master (
    input  i_REQ, i_DATA, i_TXRDY,
    output o_ACK, o_TX_WRITE, o_TX_DATA, o_GRANT_ID, o_BUSY, o_ERR
  );

  modport slave (
    output i_REQ, i_DATA, i_TXRDY,
    input  o_ACK, o_TX_WRITE, o_TX_DATA, o_GRANT_ID, o_BUSY, o_ERR
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX engine among N_REQ byte producers;
// issues a one-cycle write strobe and follows the engine's ready low/high handshake.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DW          = 8,
  parameter int LOW_TIMEOUT = 15
) (
  input  logic                   SYS_CLK,
  input  logic                   SYS_RST,
  uart_tx_arbiter_if.master      bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(LOW_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              tx_write_q, tx_write_d;
  logic [DW-1:0]     tx_data_q, tx_data_d;
  logic [PW-1:0]     grant_id_q, grant_id_d;
  logic              err_q, err_d;

  logic              found;
  logic [PW-1:0]     win;
  logic [PW:0]       sum;

  // First requesting index at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(off);
      if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
      if (!found && bus.i_REQ[sum[PW-1:0]]) begin
        found = 1'b1;
        win   = sum[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    tx_write_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (bus.i_TXRDY && found) begin
          tx_write_d = 1'b1;
          tx_data_d  = bus.i_DATA[int'(win)*DW +: DW];
          ack_d      = N_REQ'(1) << win;
          grant_id_d = win;
          ptr_d      = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
          cnt_d      = '0;
          state_d    = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!bus.i_TXRDY) begin
          state_d = WAIT_HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
          // Engine never acknowledged the write: flag it and free the port.
          if (cnt_q == CW'(LOW_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        if (bus.i_TXRDY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RST) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      tx_write_q <= 1'b0;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      tx_write_q <= tx_write_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_ACK      = ack_q;
  assign bus.o_TX_WRITE = tx_write_q;
  assign bus.o_TX_DATA  = tx_data_q;
  assign bus.o_GRANT_ID = grant_id_q;
  assign bus.o_BUSY     = (state_q != IDLE);
  assign bus.o_ERR      = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a table of per-cycle vectors plus
// hand-written sequences for engine-busy, round-robin, timeout and mid-transfer reset.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  uart_tx_arbiter_if #(.N_REQ(4), .DW(8)) bus ();

  uart_tx_arbiter #(.N_REQ(4), .DW(8), .LOW_TIMEOUT(15)) dut (
    .SYS_CLK (clk),
    .SYS_RST (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rdy;
    logic       exp_w;
    logic [3:0] exp_ack;
    logic [7:0] exp_data;
    logic [1:0] exp_gid;
    logic       exp_busy;
    logic       exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic w, input logic [3:0] ack,
                         input logic [7:0] data, input logic [1:0] gid,
                         input logic busy, input logic err);
    chk({tag, ".write"}, 32'(bus.o_TX_WRITE), 32'(w));
    chk({tag, ".ack"},   32'(bus.o_ACK),      32'(ack));
    chk({tag, ".data"},  32'(bus.o_TX_DATA),  32'(data));
    chk({tag, ".gid"},   32'(bus.o_GRANT_ID), 32'(gid));
    chk({tag, ".busy"},  32'(bus.o_BUSY),     32'(busy));
    chk({tag, ".err"},   32'(bus.o_ERR),      32'(err));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] rr_exp [5];
    int         nwr;
    int         phase;
    int         cyc;

    // rst_n, req, rdy | write, ack, data, gid, busy, err
    vecs[0]  = '{1'b0, 4'hF, 1'b1, 1'b0, 4'h0, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'hF, 1'b1, 1'b0, 4'h0, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'hF, 1'b1, 1'b1, 4'h1, 8'h10, 2'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h10, 2'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 8'h10, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'h2, 1'b1, 1'b1, 4'h2, 8'h41, 2'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 8'h41, 2'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h41, 2'd1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 8'h41, 2'd1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'h8, 1'b0, 1'b0, 4'h0, 8'h41, 2'd1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 8'h41, 2'd1, 1'b0, 1'b0};

    bus.i_DATA  = 32'h3322_4110;
    bus.i_REQ   = 4'h0;
    bus.i_TXRDY = 1'b1;
    rst_n       = 1'b1;

    for (int i = 0; i < 11; i++) begin
      rst_n       = vecs[i].rst_n;
      bus.i_REQ   = vecs[i].req;
      bus.i_TXRDY = vecs[i].rdy;
      tick();
      $display("vec %0d req=%b rdy=%b -> write=%b ack=%b data=%h gid=%0d busy=%b err=%b",
               i, vecs[i].req, vecs[i].rdy, bus.o_TX_WRITE, bus.o_ACK, bus.o_TX_DATA,
               bus.o_GRANT_ID, bus.o_BUSY, bus.o_ERR);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_w, vecs[i].exp_ack, vecs[i].exp_data,
              vecs[i].exp_gid, vecs[i].exp_busy, vecs[i].exp_err);
    end

    // Engine busy for 20 cycles: nothing may be written; ready then grants requester 2.
    bus.i_REQ   = 4'b0100;
    bus.i_TXRDY = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("busy_eng%0d.write", i), 32'(bus.o_TX_WRITE), 32'd0);
    end
    bus.i_TXRDY = 1'b1;
    tick();
    $display("engine ready: write=%b gid=%0d data=%h", bus.o_TX_WRITE, bus.o_GRANT_ID, bus.o_TX_DATA);
    chk_all("busy_grant", 1'b1, 4'b0100, 8'h22, 2'd2, 1'b1, 1'b0);

    // Round-robin against an engine model: ready drops 1 cycle after a write, back 10 later.
    do_reset();
    rr_exp[0] = 8'h10; rr_exp[1] = 8'h11; rr_exp[2] = 8'h12; rr_exp[3] = 8'h13; rr_exp[4] = 8'h10;
    bus.i_DATA  = 32'h1312_1110;
    bus.i_REQ   = 4'hF;
    bus.i_TXRDY = 1'b1;
    nwr   = 0;
    phase = -1;
    cyc   = 0;
    while (nwr < 5 && cyc < 200) begin
      tick();
      cyc++;
      if (bus.o_TX_WRITE) begin
        $display("rr write %0d: data=%h ack=%b gid=%0d", nwr, bus.o_TX_DATA, bus.o_ACK, bus.o_GRANT_ID);
        chk($sformatf("rr%0d.data", nwr), 32'(bus.o_TX_DATA), 32'(rr_exp[nwr]));
        chk($sformatf("rr%0d.ack", nwr),  32'(bus.o_ACK),     32'(4'b0001 << (nwr % 4)));
        chk($sformatf("rr%0d.gid", nwr),  32'(bus.o_GRANT_ID), 32'(nwr % 4));
        nwr++;
        phase = 0;
      end else begin
        chk("rr.ack_idle", 32'(bus.o_ACK), 32'd0);
        if (phase >= 0) phase++;
      end
      bus.i_TXRDY = !(phase >= 1 && phase <= 10);
      if (phase == 11) phase = -1;
    end
    chk("rr.write_count", 32'(nwr), 32'd5);

    // Timeout: ready stuck high after the strobe; error 15 cycles later, then the pending grant.
    bus.i_REQ = 4'h0;
    do_reset();
    bus.i_DATA  = 32'h3322_41A5;
    bus.i_REQ   = 4'b0001;
    bus.i_TXRDY = 1'b1;
    tick();
    chk_all("to_strobe", 1'b1, 4'b0001, 8'hA5, 2'd0, 1'b1, 1'b0);
    bus.i_REQ = 4'b0100;
    for (int j = 1; j <= 17; j++) begin
      tick();
      if (j < 15) begin
        chk($sformatf("to%0d.err", j),   32'(bus.o_ERR),      32'd0);
        chk($sformatf("to%0d.busy", j),  32'(bus.o_BUSY),     32'd1);
        chk($sformatf("to%0d.write", j), 32'(bus.o_TX_WRITE), 32'd0);
      end else if (j == 15) begin
        $display("timeout edge: err=%b busy=%b", bus.o_ERR, bus.o_BUSY);
        chk_all("to15", 1'b0, 4'b0000, 8'hA5, 2'd0, 1'b0, 1'b1);
      end else if (j == 16) begin
        $display("post-timeout grant: write=%b gid=%0d", bus.o_TX_WRITE, bus.o_GRANT_ID);
        chk_all("to16", 1'b1, 4'b0100, 8'h22, 2'd2, 1'b1, 1'b1);
        bus.i_REQ = 4'h0;
      end else begin
        chk("to17.err", 32'(bus.o_ERR), 32'd1);
      end
    end

    // Reset while in WAIT_HIGH; afterwards no write until ready, then requester 0 first.
    bus.i_TXRDY = 1'b0;
    tick();
    chk("rwh.busy_before", 32'(bus.o_BUSY), 32'd1);
    rst_n = 1'b0;
    tick();
    $display("reset in WAIT_HIGH: busy=%b err=%b", bus.o_BUSY, bus.o_ERR);
    chk_all("rwh_reset", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
    rst_n     = 1'b1;
    bus.i_REQ = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rwh_wait%0d.write", i), 32'(bus.o_TX_WRITE), 32'd0);
    end
    bus.i_TXRDY = 1'b1;
    tick();
    $display("after reset grant: write=%b gid=%0d data=%h", bus.o_TX_WRITE, bus.o_GRANT_ID, bus.o_TX_DATA);
    chk_all("rwh_grant", 1'b1, 4'b0001, 8'hA5, 2'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
